// File: rtl/encoder4_2_rr_pkg.sv
// Shared constants and types for the round-robin 4-to-2 encoder.
//   N    : number of request lines
//   IDXW : encoded index width, clog2(N)
package encoder_pkg;

    localparam int unsigned N    = 4;
    localparam int unsigned IDXW = 2;

    typedef logic [IDXW-1:0] idx_t;
    typedef logic [N-1:0]    req_t;

endpackage : encoder_pkg

// File: rtl/encoder4_2_rr_if.sv
// Valid/ready index channel from the encoder to its consumer.
//   out_valid : out_idx holds a valid encoded index (producer -> consumer)
//   out_idx   : granted request index             (producer -> consumer)
//   out_ready : consumer accepts when out_valid && out_ready
interface encoder4_2_rr_if;
    import encoder_pkg::*;

    logic out_valid;
    idx_t out_idx;
    logic out_ready;

    modport master (
        output out_valid,
        output out_idx,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_idx,
        output out_ready
    );

endinterface : encoder4_2_rr_if

// File: rtl/encoder4_2_rr_rr_pick.sv
// Combinational round-robin picker: first set bit of pending scanning
// ptr, ptr+1, ... wrapping modulo N.
//   pending   : pending request bits
//   ptr       : highest-priority position for this scan
//   sel_valid : any bit pending
//   sel_idx   : chosen bit index (don't care when sel_valid is low)
module rr_pick
    import encoder_pkg::*;
(
    input  req_t pending,
    input  idx_t ptr,
    output logic sel_valid,
    output idx_t sel_idx
);

    logic [2*N-1:0] dbl;
    req_t           rot;
    idx_t           offset;

    // Rotate so ptr lands at bit 0, pick lowest set bit, rotate the index back.
    always_comb begin
        dbl    = {pending, pending};
        rot    = dbl[ptr +: N];
        offset = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offset = IDXW'(i);
            end
        end
        // N is a power of two, so the IDXW-bit add wraps modulo N.
        sel_idx   = offset + ptr;
        sel_valid = |pending;
    end

endmodule : rr_pick

// File: rtl/encoder4_2_rr.sv
// Sequential 4-to-2 encoder with round-robin priority. Request lines are
// accumulated into a pending register and issued one index per transfer.
//   clk, rst_n  : clock, async active-low reset
//   req         : request lines, level or pulse, sampled every edge
//   bus         : valid/ready index output channel (master side)
//   any_pending : pending register non-zero (registered)
//   dropped     : one-cycle pulse, a request merged into an already-pending bit
module encoder4_2_rr
    import encoder_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  req_t                   req,
    encoder4_2_rr_if.master        bus,
    output logic                   any_pending,
    output logic                   dropped
);

    req_t pending;
    idx_t ptr;
    logic out_valid;
    idx_t out_idx;

    logic sel_valid_c;
    idx_t sel_idx_c;
    logic load_c;
    logic issue_c;
    req_t clr_mask_c;
    req_t next_pending_c;

    rr_pick u_rr_pick (
        .pending   (pending),
        .ptr       (ptr),
        .sel_valid (sel_valid_c),
        .sel_idx   (sel_idx_c)
    );

    // Output register may load when empty or being consumed this cycle.
    always_comb begin
        load_c         = !out_valid || bus.out_ready;
        issue_c        = load_c && sel_valid_c;
        clr_mask_c     = issue_c ? (req_t'(1) << sel_idx_c) : '0;
        // New requests override the clear of the bit being issued.
        next_pending_c = (pending & ~clr_mask_c) | req;
    end

    // Pending, pointer, output channel and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= '0;
            ptr         <= '0;
            out_valid   <= 1'b0;
            out_idx     <= '0;
            any_pending <= 1'b0;
            dropped     <= 1'b0;
        end else begin
            pending     <= next_pending_c;
            any_pending <= |next_pending_c;
            dropped     <= |(req & pending & ~clr_mask_c);
            if (load_c) begin
                out_valid <= sel_valid_c;
                if (sel_valid_c) begin
                    out_idx <= sel_idx_c;
                    ptr     <= sel_idx_c + IDXW'(1);
                end
            end
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_idx   = out_idx;

endmodule : encoder4_2_rr

// File: tb/tb_encoder4_2_rr.sv
// Directed self-checking bench for encoder4_2_rr.
module tb_encoder4_2_rr;
    import encoder_pkg::*;

    logic clk;
    logic rst_n;
    req_t req;
    logic any_pending;
    logic dropped;

    int tests;
    int fails;

    encoder4_2_rr_if bus ();

    encoder4_2_rr dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .bus         (bus.master),
        .any_pending (any_pending),
        .dropped     (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests         = 0;
        fails         = 0;
        rst_n         = 1'b0;
        req           = '0;
        bus.out_ready = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_valid", 8'(bus.out_valid), 8'd0);
        chk("rst_idx",   8'(bus.out_idx),   8'd0);
        chk("rst_anyp",  8'(any_pending),   8'd0);
        chk("rst_drop",  8'(dropped),       8'd0);
        rst_n = 1'b1;

        // Asynchronous reset mid-transfer with pending=1010
        req = 4'b1010;
        step();
        req = '0;
        chk("ar_anyp_set", 8'(any_pending),   8'd1);
        chk("ar_valid0",   8'(bus.out_valid), 8'd0);
        step();
        chk("ar_valid1",   8'(bus.out_valid), 8'd1);
        chk("ar_idx1",     8'(bus.out_idx),   8'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_async_valid", 8'(bus.out_valid), 8'd0);
        chk("ar_async_idx",   8'(bus.out_idx),   8'd0);
        chk("ar_async_anyp",  8'(any_pending),   8'd0);
        chk("ar_async_drop",  8'(dropped),       8'd0);
        #2 rst_n = 1'b1;
        step();
        chk("ar_post_valid", 8'(bus.out_valid), 8'd0);
        chk("ar_post_anyp",  8'(any_pending),   8'd0);
        step();
        chk("ar_post_valid2", 8'(bus.out_valid), 8'd0);

        // Single request: index 2 after exactly two edges
        bus.out_ready = 1'b1;
        req = 4'b0100;
        step();
        req = '0;
        chk("single_e1_valid", 8'(bus.out_valid), 8'd0);
        chk("single_e1_anyp",  8'(any_pending),   8'd1);
        step();
        chk("single_e2_valid", 8'(bus.out_valid), 8'd1);
        chk("single_e2_idx",   8'(bus.out_idx),   8'd2);
        chk("single_e2_anyp",  8'(any_pending),   8'd0);
        step();
        chk("single_e3_valid", 8'(bus.out_valid), 8'd0);
        chk("single_e3_idx",   8'(bus.out_idx),   8'd2);

        // Round-robin wrap from ptr=3: 3 then 0
        req = 4'b1001;
        step();
        req = '0;
        step();
        chk("wrap_first_valid", 8'(bus.out_valid), 8'd1);
        chk("wrap_first_idx",   8'(bus.out_idx),   8'd3);
        step();
        chk("wrap_second_valid", 8'(bus.out_valid), 8'd1);
        chk("wrap_second_idx",   8'(bus.out_idx),   8'd0);
        step();
        chk("wrap_done_valid", 8'(bus.out_valid), 8'd0);

        // ptr now 1: 0011 issues 1 before 0
        req = 4'b0011;
        step();
        req = '0;
        step();
        chk("ptr1_first_idx",  8'(bus.out_idx), 8'd1);
        step();
        chk("ptr1_second_idx", 8'(bus.out_idx), 8'd0);
        step();
        chk("ptr1_done_valid", 8'(bus.out_valid), 8'd0);

        // Reset returns ptr to 0
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

        // Back-pressure: 1111 with out_ready low for 5 cycles
        bus.out_ready = 1'b0;
        req = 4'b1111;
        step();
        req = '0;
        step();
        chk("bp_first_valid", 8'(bus.out_valid), 8'd1);
        chk("bp_first_idx",   8'(bus.out_idx),   8'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("bp_stall%0d_valid", i), 8'(bus.out_valid), 8'd1);
            chk($sformatf("bp_stall%0d_idx", i),   8'(bus.out_idx),   8'd0);
            chk($sformatf("bp_stall%0d_anyp", i),  8'(any_pending),   8'd1);
        end
        bus.out_ready = 1'b1;
        step();
        chk("bp_idx1",  8'(bus.out_idx), 8'd1);
        chk("bp_anyp1", 8'(any_pending), 8'd1);
        step();
        chk("bp_idx2",  8'(bus.out_idx), 8'd2);
        chk("bp_anyp2", 8'(any_pending), 8'd1);
        step();
        chk("bp_idx3",   8'(bus.out_idx),   8'd3);
        chk("bp_valid3", 8'(bus.out_valid), 8'd1);
        chk("bp_anyp3",  8'(any_pending),   8'd0);
        step();
        chk("bp_done_valid", 8'(bus.out_valid), 8'd0);

        // Merge: re-request bit 1 while it is pending and the output is stalled
        bus.out_ready = 1'b0;
        req = 4'b0011;
        step();
        req = '0;
        step();
        chk("merge_hold_idx",  8'(bus.out_idx), 8'd0);
        chk("merge_pre_drop",  8'(dropped),     8'd0);
        req = 4'b0010;
        step();
        req = '0;
        chk("merge_drop_pulse", 8'(dropped), 8'd1);
        step();
        chk("merge_drop_clear", 8'(dropped),     8'd0);
        chk("merge_still_idx0", 8'(bus.out_idx), 8'd0);
        bus.out_ready = 1'b1;
        step();
        chk("merge_idx1_valid", 8'(bus.out_valid), 8'd1);
        chk("merge_idx1",       8'(bus.out_idx),   8'd1);
        step();
        chk("merge_once_valid", 8'(bus.out_valid), 8'd0);
        chk("merge_once_anyp",  8'(any_pending),   8'd0);

        // Set beats clear: bit 0 held high issues every cycle
        req = 4'b0001;
        step();
        chk("sbc_first_valid", 8'(bus.out_valid), 8'd0);
        step();
        chk("sbc_start_valid", 8'(bus.out_valid), 8'd1);
        chk("sbc_start_idx",   8'(bus.out_idx),   8'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("sbc%0d_valid", i), 8'(bus.out_valid), 8'd1);
            chk($sformatf("sbc%0d_idx", i),   8'(bus.out_idx),   8'd0);
            chk($sformatf("sbc%0d_drop", i),  8'(dropped),       8'd0);
            chk($sformatf("sbc%0d_anyp", i),  8'(any_pending),   8'd1);
        end
        req = '0;
        step();
        chk("sbc_last_valid", 8'(bus.out_valid), 8'd1);
        chk("sbc_last_idx",   8'(bus.out_idx),   8'd0);
        step();
        chk("sbc_end_valid", 8'(bus.out_valid), 8'd0);
        chk("sbc_end_anyp",  8'(any_pending),   8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_encoder4_2_rr
